matmul_ctrl: RTL

Sequencer for the `matmul` datapath; it replaces that block's free-running row/col walk with a start/done-controlled job. On `start` it walks every (row, col) pair of the A×C output, driving the M1/M2 read addresses. It delays the M3 write address and enable by the operand RAM read latency so each write lines up with its dot-product result, then pulses `done`. It sits between the system controller and the dot-product/tree-sum datapath plus its three RAMs.

---
 rtl/matmul_pkg.sv | 24 ++
 rtl/matmul_ctrl_if.sv | 38 +++
 rtl/delay_line.sv | 37 +++
 rtl/matmul_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// matmul_pkg: shared types and default dimensions for the matmul datapath and its sequencer.
//   matmul_ctrl_state_t : sequencer FSM state encoding
//   DefA/DefB/DefC      : default matrix dimensions (M1 is AxB, M2 is CxB, M3 is AxC)
//   DefBits             : default element width
//   clog2_min1()        : address width helper that never returns zero
package matmul_pkg;

  localparam int unsigned DefA    = 16;
  localparam int unsigned DefB    = 8;
  localparam int unsigned DefC    = 24;
  localparam int unsigned DefBits = 16;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain
  } matmul_ctrl_state_t;

  // Keeps a 1-entry dimension from producing a zero-width address bus.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matmul_ctrl_if.sv
// matmul_ctrl_if: job handshake and RAM addressing bundle of the matmul sequencer.
//   start, abort         : job request / cancel from the system controller
//   busy, done           : job status (done is a one-cycle completion pulse)
//   rd_en, m1/m2_addr    : operand RAM read strobe and row/col addresses
//   m3_wr_ena/addr       : result RAM write strobe and flat address (row*C+col)
// Modports: master = system controller side, slave = sequencer side.
interface matmul_ctrl_if
  import matmul_pkg::*;
#(
  parameter int unsigned A = DefA,
  parameter int unsigned C = DefC
);

  localparam int unsigned RowW  = clog2_min1(A);
  localparam int unsigned ColW  = clog2_min1(C);
  localparam int unsigned AddrW = clog2_min1(A * C);

  logic             start;
  logic             abort;
  logic             busy;
  logic             done;
  logic             rd_en;
  logic [RowW-1:0]  m1_addr;
  logic [ColW-1:0]  m2_addr;
  logic [AddrW-1:0] m3_wr_addr;
  logic             m3_wr_ena;

  modport master (
    output start, abort,
    input  busy, done, rd_en, m1_addr, m2_addr, m3_wr_addr, m3_wr_ena
  );

  modport slave (
    input  start, abort,
    output busy, done, rd_en, m1_addr, m2_addr, m3_wr_addr, m3_wr_ena
  );

endinterface

// File: rtl/delay_line.sv
// delay_line: DEPTH-stage register pipeline with asynchronous clear and synchronous flush.
//   clk_i, rst_ni : clock, async active-low clear
//   flush_i       : zero every stage on the next edge
//   d_i / q_o     : data in / data out DEPTH cycles later (DEPTH=0 is a wire)
module delay_line #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_pass
    logic unused_ctrl;
    assign unused_ctrl = ^{clk_i, rst_ni, flush_i};
    assign q_o = d_i;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= '0;
      end else if (flush_i) begin
        for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= d_i;
        for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/matmul_ctrl.sv
// matmul_ctrl: start/done sequencer for the matmul datapath. Walks every (row, col) of the
// AxC result, row inner and col outer, one pair per cycle, and delays the M3 write strobe and
// flat address by RD_LAT so each write lines up with its dot-product result.
//   clk, rst_n  : clock, async active-low reset
//   bus (slave) : start/abort in; busy/done/rd_en/m1_addr/m2_addr/m3_wr_addr/m3_wr_ena out
//   perf_cycles : busy-cycle counter of the last job, only when MATMUL_CTRL_PERF_EN is defined
// Parameters: A rows, C cols, RD_LAT operand RAM read latency (0..4).
module matmul_ctrl
  import matmul_pkg::*;
#(
  parameter int unsigned A      = DefA,
  parameter int unsigned C      = DefC,
  parameter int unsigned RD_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  matmul_ctrl_if.slave bus
`ifdef MATMUL_CTRL_PERF_EN
  ,
  output logic [31:0]  perf_cycles
`endif
);

  localparam int unsigned RowW  = clog2_min1(A);
  localparam int unsigned ColW  = clog2_min1(C);
  localparam int unsigned AddrW = clog2_min1(A * C);
  localparam int unsigned CntW  = 3;

  matmul_ctrl_state_t state_q;
  logic [RowW-1:0]    row_q;
  logic [ColW-1:0]    col_q;
  logic [CntW-1:0]    drain_q;
  logic               busy_q;
  logic               done_q;
  logic               rd_en_q;

  logic               accept;
  logic               kill;
  logic               last_row;
  logic               last_col;
  logic [AddrW-1:0]   flat_addr;

  // In IDLE abort beats start; abort only kills a job that is actually running.
  assign accept   = (state_q == StIdle) && bus.start && !bus.abort;
  assign kill     = (state_q != StIdle) && bus.abort;
  assign last_row = (row_q == RowW'(A - 1));
  assign last_col = (col_q == ColW'(C - 1));

  // (A-1)*C + (C-1) = A*C-1 always fits in AddrW bits.
  assign flat_addr = AddrW'(row_q) * AddrW'(C) + AddrW'(col_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= '0;
      drain_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q <= StIssue;
            row_q   <= '0;
            col_q   <= '0;
            busy_q  <= 1'b1;
            rd_en_q <= 1'b1;
          end
        end
        StIssue: begin
          if (bus.abort) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            rd_en_q <= 1'b0;
          end else if (last_row && last_col) begin
            // Addresses hold at the final pair once issue stops.
            rd_en_q <= 1'b0;
            if (RD_LAT == 0) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= StDrain;
              drain_q <= '0;
            end
          end else if (last_row) begin
            row_q <= '0;
            col_q <= col_q + 1'b1;
          end else begin
            row_q <= row_q + 1'b1;
          end
        end
        StDrain: begin
          if (bus.abort) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (drain_q == CntW'(RD_LAT - 1)) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          rd_en_q <= 1'b0;
        end
      endcase
    end
  end

  // Write strobe and address ride together so a flushed slot never writes.
  logic [AddrW:0] wr_pipe_q;

  delay_line #(
    .WIDTH (AddrW + 1),
    .DEPTH (RD_LAT)
  ) u_wr_delay (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (kill),
    .d_i     ({rd_en_q, flat_addr}),
    .q_o     (wr_pipe_q)
  );

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.rd_en      = rd_en_q;
  assign bus.m1_addr    = row_q;
  assign bus.m2_addr    = col_q;
  assign bus.m3_wr_ena  = wr_pipe_q[AddrW];
  assign bus.m3_wr_addr = wr_pipe_q[AddrW-1:0];

`ifdef MATMUL_CTRL_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (accept) begin
      perf_q <= '0;
    end else if (busy_q && (perf_q != '1)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule
